// File: rtl/bullet_pool_controller_pkg.sv
// Shared constants for the player bullet pool and the enemy controllers that consume it.
package bullet_pool_controller_pkg;

  localparam int unsigned DEF_NUM_BULLETS = 8;
  localparam int unsigned COORD_W         = 10;
  localparam int unsigned SCREEN_W        = 640;
  localparam int unsigned SCREEN_H        = 480;
  localparam int unsigned BULLET_SIZE     = 8;
  localparam int unsigned ENEMY_SIZE      = 32;
  localparam int unsigned DEF_SPAWN_DX    = 12;
  localparam int unsigned DEF_SPAWN_DY    = 8;

  typedef logic [COORD_W-1:0] coord_t;

  // Subtraction clamped at zero so nothing spawns or moves past the screen top.
  function automatic coord_t sat_sub(coord_t a, coord_t b);
    return (a < b) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/bullet_pool_controller_slot_picker.sv
// Combinational lowest-index-zero finder over the bullet active vector.
module bullet_slot_picker #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [NUM_SLOTS-1:0] active,
  output logic [IDX_W-1:0]     slot,
  output logic                 found
);

  always_comb begin
    found = 1'b0;
    slot  = '0;
    // Scan downwards so the last hit is the lowest free index.
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!active[i]) begin
        found = 1'b1;
        slot  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bullet_pool_controller.sv
// Player bullet pool: allocates slots on fire, moves bullets up on a divided tick, retires on
// hit or off-top.
module bullet_pool_controller
  import bullet_pool_controller_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = DEF_NUM_BULLETS,
  parameter int unsigned MOVE_DIV      = 250_000,
  parameter int unsigned BULLET_STEP   = 4,
  parameter int unsigned FIRE_COOLDOWN = 8,
  parameter int unsigned SPAWN_DX      = DEF_SPAWN_DX,
  parameter int unsigned SPAWN_DY      = DEF_SPAWN_DY
) (
  input  logic                           clk25,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           fire_req,
  input  logic [COORD_W-1:0]             player_x,
  input  logic [COORD_W-1:0]             player_y,
  input  logic [NUM_BULLETS-1:0]         hit_in,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_x_flat,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_y_flat,
  output logic [NUM_BULLETS-1:0]         bullet_active_flat,
  output logic                           fire_ack,
  output logic                           pool_full,
  output logic [15:0]                    shots_fired
);

  localparam int unsigned IDX_W   = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam coord_t      STEP    = coord_t'(BULLET_STEP);
  localparam coord_t      DX      = coord_t'(SPAWN_DX);
  localparam coord_t      DY      = coord_t'(SPAWN_DY);
  localparam logic [15:0] CD_LOAD = 16'(FIRE_COOLDOWN);

  coord_t [NUM_BULLETS-1:0] x_q, x_d, y_q, y_d;
  logic [NUM_BULLETS-1:0]   active_q, active_d;
  logic [31:0]              tick_cnt_q, tick_cnt_d;
  logic [15:0]              cd_q, cd_d;
  logic [15:0]              shots_q, shots_d;
  logic                     ack_q, ack_d;

  logic             tick;
  logic             accept;
  logic             free_found;
  logic [IDX_W-1:0] free_slot;

  bullet_slot_picker #(
    .NUM_SLOTS (NUM_BULLETS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .active (active_q),
    .slot   (free_slot),
    .found  (free_found)
  );

  assign tick   = (tick_cnt_q == MOVE_DIV - 1);
  assign accept = enable && fire_req && (cd_q == '0) && free_found;

  always_comb begin
    active_d   = active_q;
    x_d        = x_q;
    y_d        = y_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
    cd_d       = (tick && cd_q != '0) ? cd_q - 16'd1 : cd_q;
    shots_d    = shots_q;
    ack_d      = 1'b0;

    // Hit beats move; a slot being freed here is not visible to the picker until next edge.
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (active_q[i]) begin
        if (hit_in[i]) begin
          active_d[i] = 1'b0;
        end else if (tick) begin
          if (y_q[i] < STEP) active_d[i] = 1'b0;
          else               y_d[i]      = y_q[i] - STEP;
        end
      end
    end

    if (accept) begin
      active_d[free_slot] = 1'b1;
      x_d[free_slot]      = player_x + DX;
      y_d[free_slot]      = sat_sub(player_y, DY);
      cd_d                = CD_LOAD;
      shots_d             = shots_q + 16'd1;
      ack_d               = 1'b1;
    end

    if (!enable) begin
      active_d   = '0;
      cd_d       = '0;
      tick_cnt_d = '0;
      ack_d      = 1'b0;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      active_q   <= '0;
      tick_cnt_q <= '0;
      cd_q       <= '0;
      shots_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      active_q   <= active_d;
      tick_cnt_q <= tick_cnt_d;
      cd_q       <= cd_d;
      shots_q    <= shots_d;
      ack_q      <= ack_d;
    end
  end

  assign bullet_x_flat      = x_q;
  assign bullet_y_flat      = y_q;
  assign bullet_active_flat = active_q;
  assign fire_ack           = ack_q;
  assign shots_fired        = shots_q;
  assign pool_full          = &active_q;

endmodule
